// File: rtl/riscv_core_trap_pkg.sv
// Shared types and constants for the trap sequencer.
//   - XLEN/ILEN defaults
//   - FSM state enum
//   - winning-stage enum
//   - exception/interrupt cause codes (low 6 bits of mcause)
package riscv_core_trap_pkg;

    localparam int TRAP_XLEN = 64;
    localparam int TRAP_ILEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } trap_state_e;

    typedef enum logic [1:0] {
        STG_MEM = 2'd0,
        STG_EXE = 2'd1,
        STG_ID  = 2'd2,
        STG_INT = 2'd3
    } trap_stage_e;

    localparam logic [5:0] CAUSE_INSTR_MISALIGN = 6'd0;
    localparam logic [5:0] CAUSE_ILLEGAL        = 6'd2;
    localparam logic [5:0] CAUSE_BREAKPOINT     = 6'd3;
    localparam logic [5:0] CAUSE_LOAD_FAULT     = 6'd5;
    localparam logic [5:0] CAUSE_STORE_FAULT    = 6'd7;
    localparam logic [5:0] CAUSE_ECALL_M        = 6'd11;
    localparam logic [5:0] CAUSE_IRQ_TIMER      = 6'd7;
    localparam logic [5:0] CAUSE_IRQ_EXT        = 6'd11;

endpackage

// File: rtl/riscv_core_trap_ctrl_if.sv
// Fetch-redirect handshake between the trap sequencer and the fetch unit.
//   redirect_valid : target PC is being offered
//   redirect_pc    : target PC
//   redirect_ready : fetch accepts the target
// master = trap sequencer, slave = fetch unit.
interface riscv_core_trap_ctrl_if
    import riscv_core_trap_pkg::*;
#(
    parameter int ILEN = TRAP_ILEN
);
    logic            redirect_valid;
    logic [ILEN-1:0] redirect_pc;
    logic            redirect_ready;

    modport master (output redirect_valid, output redirect_pc, input redirect_ready);
    modport slave  (input redirect_valid, input redirect_pc, output redirect_ready);
endinterface

// File: rtl/riscv_core_trap_prio.sv
// Combinational priority encoder for trap sources.
// Inputs : ID/EXE/MEM exception flags, mret, interrupt enable/pending bits,
//          id_valid (interrupts are only taken on a valid ID instruction).
// Outputs: o_valid (something wins), o_cause (full mcause value),
//          o_stage (winning stage), o_is_mret.
module riscv_core_trap_prio
    import riscv_core_trap_pkg::*;
#(
    parameter int XLEN = TRAP_XLEN
) (
    input  logic            i_id_valid,
    input  logic            i_illegal_id,
    input  logic            i_ecall,
    input  logic            i_ebreak,
    input  logic            i_mret,
    input  logic            i_illegal_exe,
    input  logic            i_misaligned,
    input  logic            i_lw_fault,
    input  logic            i_sw_fault,
    input  logic            i_mstatus_mie,
    input  logic            i_meie,
    input  logic            i_meip,
    input  logic            i_mtie,
    input  logic            i_mtip,
    output logic            o_valid,
    output logic [XLEN-1:0] o_cause,
    output trap_stage_e     o_stage,
    output logic            o_is_mret
);
    logic w_ext_irq;
    logic w_tmr_irq;

    function automatic logic [XLEN-1:0] mk_cause(input logic irq, input logic [5:0] code);
        return {irq, {(XLEN-7){1'b0}}, code};
    endfunction

    assign w_ext_irq = i_id_valid & i_mstatus_mie & i_meie & i_meip;
    assign w_tmr_irq = i_id_valid & i_mstatus_mie & i_mtie & i_mtip;

    // Older pipeline stages win; mret outranks interrupts so an in-flight
    // return completes before the next interrupt is taken.
    always_comb begin
        o_valid   = 1'b1;
        o_cause   = '0;
        o_stage   = STG_ID;
        o_is_mret = 1'b0;
        if (i_sw_fault) begin
            o_cause = mk_cause(1'b0, CAUSE_STORE_FAULT);
            o_stage = STG_MEM;
        end else if (i_lw_fault) begin
            o_cause = mk_cause(1'b0, CAUSE_LOAD_FAULT);
            o_stage = STG_MEM;
        end else if (i_misaligned) begin
            o_cause = mk_cause(1'b0, CAUSE_INSTR_MISALIGN);
            o_stage = STG_EXE;
        end else if (i_illegal_exe) begin
            o_cause = mk_cause(1'b0, CAUSE_ILLEGAL);
            o_stage = STG_EXE;
        end else if (i_illegal_id) begin
            o_cause = mk_cause(1'b0, CAUSE_ILLEGAL);
        end else if (i_ecall) begin
            o_cause = mk_cause(1'b0, CAUSE_ECALL_M);
        end else if (i_ebreak) begin
            o_cause = mk_cause(1'b0, CAUSE_BREAKPOINT);
        end else if (i_mret) begin
            o_is_mret = 1'b1;
        end else if (w_ext_irq) begin
            o_cause = mk_cause(1'b1, CAUSE_IRQ_EXT);
            o_stage = STG_INT;
        end else if (w_tmr_irq) begin
            o_cause = mk_cause(1'b1, CAUSE_IRQ_TIMER);
            o_stage = STG_INT;
        end else begin
            o_valid = 1'b0;
        end
    end
endmodule

// File: rtl/riscv_core_trap_ctrl.sv
// Trap sequencer: accepts the highest-priority trap/mret in IDLE, flushes
// the affected stages, waits for outstanding memory traffic, emits a single
// CSR commit pulse and redirects fetch.
// Ports: clock/reset, ID/EXE/MEM pc+instr, exception/interrupt flags,
// mtvec/mepc, mem_busy; stage flushes, stall, trap/mret commit pulses,
// registered cause/epc/tval/tinst, irq_ack; redirect handshake via
// riscv_core_trap_ctrl_if.master.
//
// state    | meaning
// IDLE     | sample events, accept the winner
// DRAIN    | wait for data-memory transaction to finish
// COMMIT   | one-cycle trap_we / mret_we (and irq_ack) pulse
// REDIRECT | offer target PC to fetch until redirect_ready
module riscv_core_trap_ctrl
    import riscv_core_trap_pkg::*;
#(
    parameter int XLEN = TRAP_XLEN,
    parameter int ILEN = TRAP_ILEN
) (
    input  logic            i_trap_ctrl_clk,
    input  logic            i_trap_ctrl_rst_n,
    input  logic            i_trap_ctrl_id_valid,
    input  logic [ILEN-1:0] i_trap_ctrl_id_pc,
    input  logic [ILEN-1:0] i_trap_ctrl_id_instr,
    input  logic [ILEN-1:0] i_trap_ctrl_exe_pc,
    input  logic [ILEN-1:0] i_trap_ctrl_exe_instr,
    input  logic [ILEN-1:0] i_trap_ctrl_mem_pc,
    input  logic [ILEN-1:0] i_trap_ctrl_mem_instr,
    input  logic            i_trap_ctrl_illegal_id,
    input  logic            i_trap_ctrl_ecall,
    input  logic            i_trap_ctrl_ebreak,
    input  logic            i_trap_ctrl_mret,
    input  logic            i_trap_ctrl_illegal_exe,
    input  logic            i_trap_ctrl_misaligned,
    input  logic            i_trap_ctrl_lw_fault,
    input  logic            i_trap_ctrl_sw_fault,
    input  logic [XLEN-1:0] i_trap_ctrl_fault_addr,
    input  logic            i_trap_ctrl_mstatus_mie,
    input  logic            i_trap_ctrl_meie,
    input  logic            i_trap_ctrl_meip,
    input  logic            i_trap_ctrl_mtie,
    input  logic            i_trap_ctrl_mtip,
    input  logic [ILEN-1:0] i_trap_ctrl_mtvec,
    input  logic [ILEN-1:0] i_trap_ctrl_mepc,
    input  logic            i_trap_ctrl_mem_busy,
    output logic            o_trap_ctrl_flush_if,
    output logic            o_trap_ctrl_flush_id,
    output logic            o_trap_ctrl_flush_exe,
    output logic            o_trap_ctrl_flush_mem,
    output logic            o_trap_ctrl_stall,
    output logic            o_trap_ctrl_trap_we,
    output logic            o_trap_ctrl_mret_we,
    output logic [XLEN-1:0] o_trap_ctrl_cause,
    output logic [ILEN-1:0] o_trap_ctrl_epc,
    output logic [XLEN-1:0] o_trap_ctrl_tval,
    output logic [ILEN-1:0] o_trap_ctrl_tinst,
    output logic            o_trap_ctrl_irq_ack,
    riscv_core_trap_ctrl_if.master trap_ctrl_redirect
);
    trap_state_e     r_state, w_state_nxt;
    logic            r_is_mret, r_is_ext;
    logic [ILEN-1:0] r_redirect_pc;

    logic            w_valid, w_is_mret, w_accept;
    logic [XLEN-1:0] w_cause;
    trap_stage_e     w_stage;
    logic [ILEN-1:0] w_epc, w_tinst, w_base, w_target;

    riscv_core_trap_prio #(.XLEN(XLEN)) u_prio (
        .i_id_valid    (i_trap_ctrl_id_valid),
        .i_illegal_id  (i_trap_ctrl_illegal_id),
        .i_ecall       (i_trap_ctrl_ecall),
        .i_ebreak      (i_trap_ctrl_ebreak),
        .i_mret        (i_trap_ctrl_mret),
        .i_illegal_exe (i_trap_ctrl_illegal_exe),
        .i_misaligned  (i_trap_ctrl_misaligned),
        .i_lw_fault    (i_trap_ctrl_lw_fault),
        .i_sw_fault    (i_trap_ctrl_sw_fault),
        .i_mstatus_mie (i_trap_ctrl_mstatus_mie),
        .i_meie        (i_trap_ctrl_meie),
        .i_meip        (i_trap_ctrl_meip),
        .i_mtie        (i_trap_ctrl_mtie),
        .i_mtip        (i_trap_ctrl_mtip),
        .o_valid       (w_valid),
        .o_cause       (w_cause),
        .o_stage       (w_stage),
        .o_is_mret     (w_is_mret)
    );

    assign w_accept = (r_state == ST_IDLE) & w_valid;

    always_comb begin
        w_epc   = i_trap_ctrl_id_pc;
        w_tinst = i_trap_ctrl_id_instr;
        case (w_stage)
            STG_MEM: begin
                w_epc   = i_trap_ctrl_mem_pc;
                w_tinst = i_trap_ctrl_mem_instr;
            end
            STG_EXE: begin
                w_epc   = i_trap_ctrl_exe_pc;
                w_tinst = i_trap_ctrl_exe_instr;
            end
            STG_INT: w_tinst = '0;
            default: ;
        endcase
    end

    // Vectored mode only applies to interrupts; the offset is cause*4.
    assign w_base = {i_trap_ctrl_mtvec[ILEN-1:2], 2'b00};
    always_comb begin
        w_target = w_base;
        if (r_is_mret)
            w_target = i_trap_ctrl_mepc;
        else if ((i_trap_ctrl_mtvec[1:0] == 2'b01) && o_trap_ctrl_cause[XLEN-1])
            w_target = w_base + {{(ILEN-8){1'b0}}, o_trap_ctrl_cause[5:0], 2'b00};
    end

    always_ff @(posedge i_trap_ctrl_clk or negedge i_trap_ctrl_rst_n) begin
        if (!i_trap_ctrl_rst_n) begin
            r_state           <= ST_IDLE;
            r_is_mret         <= 1'b0;
            r_is_ext          <= 1'b0;
            r_redirect_pc     <= '0;
            o_trap_ctrl_cause <= '0;
            o_trap_ctrl_epc   <= '0;
            o_trap_ctrl_tval  <= '0;
            o_trap_ctrl_tinst <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_is_mret         <= w_is_mret;
                r_is_ext          <= (w_stage == STG_INT) && (w_cause[5:0] == CAUSE_IRQ_EXT);
                o_trap_ctrl_cause <= w_cause;
                o_trap_ctrl_epc   <= w_epc;
                o_trap_ctrl_tval  <= (w_stage == STG_MEM) ? i_trap_ctrl_fault_addr : '0;
                o_trap_ctrl_tinst <= w_tinst;
            end
            if (r_state == ST_COMMIT)
                r_redirect_pc <= w_target;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (w_valid) w_state_nxt = i_trap_ctrl_mem_busy ? ST_DRAIN : ST_COMMIT;
            ST_DRAIN:    if (!i_trap_ctrl_mem_busy) w_state_nxt = ST_COMMIT;
            ST_COMMIT:   w_state_nxt = ST_REDIRECT;
            ST_REDIRECT: if (trap_ctrl_redirect.redirect_ready) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_trap_ctrl_stall     = (r_state != ST_IDLE);
        o_trap_ctrl_flush_if  = o_trap_ctrl_stall | w_accept;
        o_trap_ctrl_flush_id  = w_accept;
        o_trap_ctrl_flush_exe = w_accept & ((w_stage == STG_MEM) || (w_stage == STG_EXE));
        o_trap_ctrl_flush_mem = w_accept & (w_stage == STG_MEM);
        o_trap_ctrl_trap_we   = (r_state == ST_COMMIT) & ~r_is_mret;
        o_trap_ctrl_mret_we   = (r_state == ST_COMMIT) & r_is_mret;
        o_trap_ctrl_irq_ack   = (r_state == ST_COMMIT) & r_is_ext;
    end

    assign trap_ctrl_redirect.redirect_valid = (r_state == ST_REDIRECT);
    assign trap_ctrl_redirect.redirect_pc    = r_redirect_pc;
endmodule

// File: tb/tb_riscv_core_trap_ctrl.sv
module tb_riscv_core_trap_ctrl;
    import riscv_core_trap_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        id_valid, illegal_id, ecall, ebreak, mret, illegal_exe, misaligned, lw_fault, sw_fault;
    logic        mie, meie, meip, mtie, mtip, mem_busy;
    logic [31:0] id_pc, id_instr, exe_pc, exe_instr, mem_pc, mem_instr, mtvec, mepc;
    logic [63:0] fault_addr;
    logic        flush_if, flush_id, flush_exe, flush_mem, stall, trap_we, mret_we, irq_ack;
    logic [63:0] cause, tval;
    logic [31:0] epc, tinst;

    riscv_core_trap_ctrl_if #(.ILEN(32)) redir ();

    riscv_core_trap_ctrl #(.XLEN(64), .ILEN(32)) dut (
        .i_trap_ctrl_clk(clk), .i_trap_ctrl_rst_n(rst_n),
        .i_trap_ctrl_id_valid(id_valid), .i_trap_ctrl_id_pc(id_pc), .i_trap_ctrl_id_instr(id_instr),
        .i_trap_ctrl_exe_pc(exe_pc), .i_trap_ctrl_exe_instr(exe_instr),
        .i_trap_ctrl_mem_pc(mem_pc), .i_trap_ctrl_mem_instr(mem_instr),
        .i_trap_ctrl_illegal_id(illegal_id), .i_trap_ctrl_ecall(ecall), .i_trap_ctrl_ebreak(ebreak),
        .i_trap_ctrl_mret(mret), .i_trap_ctrl_illegal_exe(illegal_exe), .i_trap_ctrl_misaligned(misaligned),
        .i_trap_ctrl_lw_fault(lw_fault), .i_trap_ctrl_sw_fault(sw_fault), .i_trap_ctrl_fault_addr(fault_addr),
        .i_trap_ctrl_mstatus_mie(mie), .i_trap_ctrl_meie(meie), .i_trap_ctrl_meip(meip),
        .i_trap_ctrl_mtie(mtie), .i_trap_ctrl_mtip(mtip),
        .i_trap_ctrl_mtvec(mtvec), .i_trap_ctrl_mepc(mepc), .i_trap_ctrl_mem_busy(mem_busy),
        .o_trap_ctrl_flush_if(flush_if), .o_trap_ctrl_flush_id(flush_id),
        .o_trap_ctrl_flush_exe(flush_exe), .o_trap_ctrl_flush_mem(flush_mem),
        .o_trap_ctrl_stall(stall), .o_trap_ctrl_trap_we(trap_we), .o_trap_ctrl_mret_we(mret_we),
        .o_trap_ctrl_cause(cause), .o_trap_ctrl_epc(epc), .o_trap_ctrl_tval(tval),
        .o_trap_ctrl_tinst(tinst), .o_trap_ctrl_irq_ack(irq_ack),
        .trap_ctrl_redirect(redir)
    );

    typedef struct {
        logic        id_valid, illegal_id, ecall, ebreak, mret, illegal_exe, misaligned, lw_fault, sw_fault;
        logic        mie, meie, meip, mtie, mtip;
        logic [31:0] id_pc, id_instr, exe_pc, exe_instr, mem_pc, mem_instr, mtvec, mepc;
        logic [63:0] fault_addr;
    } stim_t;

    typedef struct {
        logic        valid, is_mret, is_ext, fl_exe, fl_mem;
        logic [63:0] cause, tval;
        logic [31:0] epc, tinst, target;
    } exp_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic stim_t blank();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        logic [31:0] r;
        s.id_valid    = ($urandom_range(0, 3) != 0);
        s.illegal_id  = ($urandom_range(0, 7) == 0);
        s.ecall       = ($urandom_range(0, 7) == 0);
        s.ebreak      = ($urandom_range(0, 7) == 0);
        s.mret        = ($urandom_range(0, 7) == 0);
        s.illegal_exe = ($urandom_range(0, 7) == 0);
        s.misaligned  = ($urandom_range(0, 7) == 0);
        s.lw_fault    = ($urandom_range(0, 7) == 0);
        s.sw_fault    = ($urandom_range(0, 7) == 0);
        s.mie  = ($urandom_range(0, 3) != 0);
        s.meie = $urandom_range(0, 1) != 0;
        s.meip = $urandom_range(0, 1) != 0;
        s.mtie = $urandom_range(0, 1) != 0;
        s.mtip = $urandom_range(0, 1) != 0;
        s.id_pc     = $urandom() & 32'hFFFF_FFFC;
        s.exe_pc    = $urandom() & 32'hFFFF_FFFC;
        s.mem_pc    = $urandom() & 32'hFFFF_FFFC;
        s.id_instr  = $urandom();
        s.exe_instr = $urandom();
        s.mem_instr = $urandom();
        r = $urandom();
        // Bias mtvec towards the top of memory sometimes so vectored sums wrap.
        s.mtvec = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | {30'd0, r[1:0]}) : r;
        s.mepc  = $urandom() & 32'hFFFF_FFFC;
        s.fault_addr = {$urandom(), $urandom()};
        return s;
    endfunction

    function automatic stim_t no_events(input stim_t s);
        stim_t z;
        z = blank();
        z.id_pc = s.id_pc;
        z.mtvec = s.mtvec;
        z.mepc  = s.mepc;
        return z;
    endfunction

    // Reference: scan an ordered table of candidate sources, first firing wins.
    function automatic exp_t model(input stim_t s);
        exp_t        e;
        logic        fire [10];
        logic [63:0] cs   [10];
        int          stg  [10];   // 0 MEM, 1 EXE, 2 ID, 3 interrupt
        logic        irq_ok;
        int          k;
        logic [31:0] base;
        irq_ok = s.mie & s.id_valid;
        fire = '{s.sw_fault, s.lw_fault, s.misaligned, s.illegal_exe, s.illegal_id, s.ecall, s.ebreak,
                 s.mret, irq_ok & s.meie & s.meip, irq_ok & s.mtie & s.mtip};
        cs   = '{64'd7, 64'd5, 64'd0, 64'd2, 64'd2, 64'd11, 64'd3, 64'd0,
                 64'h8000_0000_0000_000B, 64'h8000_0000_0000_0007};
        stg  = '{0, 0, 1, 1, 2, 2, 2, 2, 3, 3};
        k = -1;
        for (int i = 0; i < 10; i++)
            if (fire[i] && k < 0) k = i;
        e = '{default: '0};
        if (k < 0) return e;
        e.valid   = 1'b1;
        e.is_mret = (k == 7);
        e.is_ext  = (k == 8);
        e.fl_exe  = (stg[k] <= 1);
        e.fl_mem  = (stg[k] == 0);
        e.cause   = cs[k];
        e.tval    = (stg[k] == 0) ? s.fault_addr : 64'd0;
        case (stg[k])
            0:       begin e.epc = s.mem_pc; e.tinst = s.mem_instr; end
            1:       begin e.epc = s.exe_pc; e.tinst = s.exe_instr; end
            2:       begin e.epc = s.id_pc;  e.tinst = s.id_instr;  end
            default: begin e.epc = s.id_pc;  e.tinst = 32'd0;       end
        endcase
        base = s.mtvec & 32'hFFFF_FFFC;
        if (e.is_mret)
            e.target = s.mepc;
        else if (s.mtvec[1:0] == 2'b01 && stg[k] == 3)
            e.target = base + 32'(cs[k] % 64) * 32'd4;
        else
            e.target = base;
        return e;
    endfunction

    task automatic drive(input stim_t s);
        id_valid = s.id_valid; illegal_id = s.illegal_id; ecall = s.ecall; ebreak = s.ebreak;
        mret = s.mret; illegal_exe = s.illegal_exe; misaligned = s.misaligned;
        lw_fault = s.lw_fault; sw_fault = s.sw_fault;
        mie = s.mie; meie = s.meie; meip = s.meip; mtie = s.mtie; mtip = s.mtip;
        id_pc = s.id_pc; id_instr = s.id_instr; exe_pc = s.exe_pc; exe_instr = s.exe_instr;
        mem_pc = s.mem_pc; mem_instr = s.mem_instr; mtvec = s.mtvec; mepc = s.mepc;
        fault_addr = s.fault_addr;
    endtask

    // One full transaction: accept cycle, d_cyc drain cycles, commit, redirect
    // held r_cyc cycles without ready, then back to idle.
    task automatic run_txn(input stim_t s, input int d_cyc, input int r_cyc);
        exp_t  e;
        stim_t g;
        e = model(s);
        @(negedge clk);
        drive(s);
        mem_busy = e.valid && (d_cyc > 0);
        redir.redirect_ready = 1'b0;
        #1;
        chk("acc_flush_if",  flush_if,  e.valid);
        chk("acc_flush_id",  flush_id,  e.valid);
        chk("acc_flush_exe", flush_exe, e.fl_exe);
        chk("acc_flush_mem", flush_mem, e.fl_mem);
        chk("acc_stall",     stall,     1'b0);
        if (!e.valid) begin
            @(negedge clk);
            drive(no_events(s));
            mem_busy = 1'b0;
            #1;
            chk("noacc_stall",   stall,   1'b0);
            chk("noacc_trap_we", trap_we, 1'b0);
            return;
        end
        for (int d = 0; d < d_cyc; d++) begin
            @(negedge clk);
            g = rand_stim(); g.mtvec = s.mtvec; g.mepc = s.mepc;
            drive(g);
            mem_busy = (d < d_cyc - 1);
            #1;
            chk("drain_stall",    stall,    1'b1);
            chk("drain_flush_if", flush_if, 1'b1);
            chk("drain_trap_we",  trap_we,  1'b0);
            chk("drain_mret_we",  mret_we,  1'b0);
        end
        @(negedge clk);
        g = rand_stim(); g.mtvec = s.mtvec; g.mepc = s.mepc;
        drive(g);
        mem_busy = ($urandom_range(0, 1) != 0);
        #1;
        chk("cmt_trap_we", trap_we, !e.is_mret);
        chk("cmt_mret_we", mret_we, e.is_mret);
        chk("cmt_irq_ack", irq_ack, e.is_ext);
        chk("cmt_cause",   cause,   e.cause);
        chk("cmt_epc",     epc,     e.epc);
        chk("cmt_tval",    tval,    e.tval);
        chk("cmt_tinst",   tinst,   e.tinst);
        chk("cmt_stall",   stall,   1'b1);
        chk("cmt_rvalid",  redir.redirect_valid, 1'b0);
        for (int r = 0; r <= r_cyc; r++) begin
            @(negedge clk);
            drive(no_events(s));
            mem_busy = 1'b0;
            redir.redirect_ready = (r == r_cyc);
            #1;
            chk("rd_valid",   redir.redirect_valid, 1'b1);
            chk("rd_pc",      redir.redirect_pc,    e.target);
            chk("rd_trap_we", trap_we | mret_we | irq_ack, 1'b0);
            chk("rd_stall",   stall, 1'b1);
        end
        @(negedge clk);
        redir.redirect_ready = 1'b0;
        #1;
        chk("end_stall",  stall, 1'b0);
        chk("end_rvalid", redir.redirect_valid, 1'b0);
        chk("end_cause",  cause, e.cause);
        chk("end_epc",    epc,   e.epc);
    endtask

    stim_t s;

    initial begin
        drive(blank());
        mem_busy = 1'b0;
        redir.redirect_ready = 1'b0;
        #12;
        chk("rst_stall",  stall, 1'b0);
        chk("rst_flush",  {flush_if, flush_id, flush_exe, flush_mem}, 4'd0);
        chk("rst_pulses", {trap_we, mret_we, irq_ack}, 3'd0);
        chk("rst_cause",  cause, 64'd0);
        chk("rst_rvalid", redir.redirect_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Illegal instruction in ID.
        s = blank(); s.illegal_id = 1'b1; s.id_valid = 1'b1; s.id_pc = 32'h100; s.mtvec = 32'h800;
        run_txn(s, 0, 0);
        // Load fault beats a concurrent ecall.
        s = blank(); s.lw_fault = 1'b1; s.ecall = 1'b1; s.id_valid = 1'b1; s.fault_addr = 64'hDEAD;
        s.mem_pc = 32'h2000; s.mem_instr = 32'h0000_2003; s.mtvec = 32'h800;
        run_txn(s, 0, 1);
        // Timer interrupt, vectored mtvec.
        s = blank(); s.id_valid = 1'b1; s.mie = 1'b1; s.mtie = 1'b1; s.mtip = 1'b1;
        s.id_pc = 32'h400; s.id_instr = 32'h13; s.mtvec = 32'h801;
        run_txn(s, 0, 0);
        // Interrupt pending but no valid ID instruction: not taken.
        s.id_valid = 1'b0;
        run_txn(s, 0, 0);
        // Trap behind a 3-cycle memory transaction.
        s = blank(); s.ecall = 1'b1; s.id_pc = 32'h180; s.mtvec = 32'h900;
        run_txn(s, 3, 0);
        // mret beats a pending external interrupt, which is taken afterwards.
        s = blank(); s.mret = 1'b1; s.id_valid = 1'b1; s.mie = 1'b1; s.meie = 1'b1; s.meip = 1'b1;
        s.mepc = 32'h240; s.id_pc = 32'h500; s.mtvec = 32'h801;
        run_txn(s, 0, 0);
        s.mret = 1'b0;
        run_txn(s, 1, 2);

        // Reset during REDIRECT with ready low.
        s = blank(); s.illegal_id = 1'b1; s.id_pc = 32'h300; s.mtvec = 32'h900;
        @(negedge clk); drive(s); redir.redirect_ready = 1'b0;
        @(negedge clk); drive(no_events(s));
        @(negedge clk); #1;
        chk("prerst_rvalid", redir.redirect_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rvalid", redir.redirect_valid, 1'b0);
        chk("midrst_rpc",    redir.redirect_pc, 32'd0);
        chk("midrst_stall",  {stall, flush_if}, 2'd0);
        chk("midrst_fields", {cause[31:0], epc, tinst}, 96'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("postrst_idle", {stall, trap_we, mret_we, irq_ack, redir.redirect_valid}, 5'd0);
        end

        for (int t = 0; t < 300; t++)
            run_txn(rand_stim(), $urandom_range(0, 3), $urandom_range(0, 2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
